mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the pipelined MIPS core's instruction-fetch port and data-memory port onto one shared single-port backing RAM with variable latency. It sits between Stage_IF / Stage_MEM and the RAM. It sequences each access through a small FSM and returns per-port acknowledge, read data and stall signals to the pipeline. Data accesses have priority, and a streak counter bounds instruction-fetch starvation.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_DATA_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- IF_Req  in  1  fetch request, held until IF_Ack
- IF_Address  in  ADDR_W  fetch address, stable while IF_Req
- IF_Ack  out  1  one-cycle pulse, fetch complete
- IF_Read_Data  out  DATA_W  fetched word, valid with IF_Ack and held until next fetch ack
- Mem_Read, Mem_Write  in  1 each  data request, held until Mem_Ack
- Mem_Address  in  ADDR_W  data address
- Mem_Write_Data  in  DATA_W  store data
- Mem_Ack  out  1  one-cycle pulse, data access complete
- Mem_Read_Data  out  DATA_W  load word, valid with Mem_Ack and held
- Stall_IF  out  1  IF_Req & ~IF_Ack (combinational)
- Stall_MEM  out  1  (Mem_Read|Mem_Write) & ~Mem_Ack (combinational)
- Ram_Req  out  1  RAM access strobe, held until Ram_Ready
- Ram_We  out  1  write enable, valid with Ram_Req
- Ram_Address  out  ADDR_W  registered RAM address
- Ram_Write_Data  out  DATA_W  registered RAM store data
- Ram_Ready  in  1  RAM completes the current access this cycle
- Ram_Read_Data  in  DATA_W  read word, valid with Ram_Ready
- Protocol_Error  out  1  sticky; cleared only by reset

## Operation
- FSM states: IDLE, SERVE_IF, SERVE_MEM.
- IDLE, grant decision:
  - Data request only: go to SERVE_MEM.
  - Fetch request only: go to SERVE_IF.
  - Both requesting: SERVE_MEM, unless streak == MAX_DATA_STREAK, then SERVE_IF.
- On the grant edge, latch the address, write data and We. Ram_Req is registered high from the next cycle.
- SERVE_x: hold Ram_Req and all Ram_* outputs stable until Ram_Ready=1. On that edge:
  - capture Ram_Read_Data into the port's read register (reads only);
  - pulse that port's Ack on the next cycle;
  - return to IDLE.
- IDLE always takes at least one cycle between grants. No back-to-back RAM strobes.
- Streak counter, width clog2(MAX_DATA_STREAK+1):
  - +1 on a data grant while IF_Req=1;
  - cleared on any fetch grant, or on a data grant with IF_Req=0;
  - saturates at MAX_DATA_STREAK.
- Mem_Read & Mem_Write both high: perform a write, and set Protocol_Error.
- A requester dropping its request before Ack sets Protocol_Error. An access already in flight completes, but no Ack is pulsed to it.
- A write never changes Mem_Read_Data.

## Timing
- Reset (async, immediate):
  - state=IDLE, streak=0;
  - Ram_Req, Ram_We, IF_Ack, Mem_Ack, Protocol_Error = 0;
  - Ram_Address, Ram_Write_Data, IF_Read_Data, Mem_Read_Data = 0.
- Reset mid-access aborts the access; Ram_Req drops without waiting for Ram_Ready.
- Minimum latency with the RAM ready at the first strobe cycle:
  - request sampled at edge 0;
  - Ram_Req high in cycle 1;
  - Ram_Ready sampled at edge 2;
  - Ack high in cycle 2→3.
- Each RAM wait cycle adds one cycle of latency.
- Ack is high for exactly one cycle. The requester may drop or change its request in the cycle after Ack.
- Ram_Ready seen outside SERVE_x is ignored and sets Protocol_Error.

## Structure
- Shared package: FSM state encoding (2-bit localparams IDLE=0, SERVE_IF=1, SERVE_MEM=2) and the default MAX_DATA_STREAK.
- One sub-module is natural: streak_counter (saturating counter plus grant-priority decision).

## Test plan
- Fetch only, IF_Address=0x40, Ram_Ready in cycle 1, Ram_Read_Data=0x8C010004 → Ram_Req in cycle 1 only, IF_Ack in cycle 2, IF_Read_Data=0x8C010004, Stall_IF high in cycles 0–1.
- Both ports request continuously, MAX_DATA_STREAK=4, zero-wait RAM → grant order MEM,MEM,MEM,MEM,IF repeating; streak returns to 0 after the IF grant.
- Store Mem_Address=0x100, data 0xDEADBEEF, RAM waits 3 cycles → Ram_We=1, address and data stable for 4 strobe cycles, Mem_Ack one cycle after Ram_Ready, Mem_Read_Data unchanged.
- Reset asserted while Ram_Req=1 in SERVE_MEM → Ram_Req and all outputs 0 immediately; after release, the pending IF_Req is served normally.
- Mem_Read=Mem_Write=1 → write performed, Protocol_Error=1 and sticky through later clean accesses until rst_n low.
- Fetch request dropped mid-access → no IF_Ack, Protocol_Error=1, FSM back in IDLE after Ram_Ready.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Holds the FSM encoding and the default starvation bound.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE_IF  = 2'd1;
  localparam logic [1:0] SERVE_MEM = 2'd2;

  localparam int MAX_DATA_STREAK_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Grant-priority decision with a saturating data-streak counter
// that bounds how long a pending fetch can be starved.
module streak_counter #(
  parameter int MAX = 4,
  parameter int SW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en,
  input  logic if_rq,
  input  logic mem_rq,
  output logic grant_if,
  output logic grant_mem
);

  logic [SW-1:0] streak;
  logic          at_max;

  always_comb begin
    at_max    = (streak == SW'(MAX));
    grant_mem = grant_en & mem_rq & ~(if_rq & at_max);
    grant_if  = grant_en & if_rq & ~grant_mem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_mem) begin
      if (!if_rq)
        streak <= '0;
      else if (!at_max)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port RAM between the
// instruction-fetch and data ports; data wins, fetch is bounded.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Address,
  output logic              IF_Ack,
  output logic [DATA_W-1:0] IF_Read_Data,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [ADDR_W-1:0] Mem_Address,
  input  logic [DATA_W-1:0] Mem_Write_Data,
  output logic              Mem_Ack,
  output logic [DATA_W-1:0] Mem_Read_Data,
  output logic              Stall_IF,
  output logic              Stall_MEM,
  output logic              Ram_Req,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Address,
  output logic [DATA_W-1:0] Ram_Write_Data,
  input  logic              Ram_Ready,
  input  logic [DATA_W-1:0] Ram_Read_Data,
  output logic              Protocol_Error
);

  logic [1:0] state, state_d;
  logic       mem_any, grant_en;
  logic       grant_if, grant_mem;
  logic       serve_if, serve_mem;
  logic       drop_now, drop_q, stray_rdy;

  streak_counter #(
    .MAX (MAX_DATA_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_en  (grant_en),
    .if_rq     (IF_Req),
    .mem_rq    (mem_any),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (grant_mem)     state_d = SERVE_MEM;
        else if (grant_if) state_d = SERVE_IF;
      end
      SERVE_IF,
      SERVE_MEM: if (Ram_Ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The ack cycle stalls new grants so a still-held request is not re-served.
  always_comb begin
    mem_any   = Mem_Read | Mem_Write;
    serve_if  = (state == SERVE_IF);
    serve_mem = (state == SERVE_MEM);
    grant_en  = (state == IDLE) & ~IF_Ack & ~Mem_Ack;
    drop_now  = (serve_if & ~IF_Req) | (serve_mem & ~mem_any);
    stray_rdy = (state == IDLE) & Ram_Ready;
    Stall_IF  = IF_Req & ~IF_Ack;
    Stall_MEM = mem_any & ~Mem_Ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ram_Req        <= 1'b0;
      Ram_We         <= 1'b0;
      Ram_Address    <= '0;
      Ram_Write_Data <= '0;
      IF_Ack         <= 1'b0;
      Mem_Ack        <= 1'b0;
      IF_Read_Data   <= '0;
      Mem_Read_Data  <= '0;
      Protocol_Error <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      Ram_Req <= (state_d != IDLE);
      IF_Ack  <= serve_if & Ram_Ready & ~drop_q & IF_Req;
      Mem_Ack <= serve_mem & Ram_Ready & ~drop_q & mem_any;
      if (grant_mem) begin
        Ram_Address    <= Mem_Address;
        Ram_Write_Data <= Mem_Write_Data;
        Ram_We         <= Mem_Write;
      end else if (grant_if) begin
        Ram_Address <= IF_Address;
        Ram_We      <= 1'b0;
      end
      if (grant_if | grant_mem) drop_q <= 1'b0;
      else if (drop_now)        drop_q <= 1'b1;
      if (serve_if & Ram_Ready)
        IF_Read_Data <= Ram_Read_Data;
      if (serve_mem & Ram_Ready & ~Ram_We)
        Mem_Read_Data <= Ram_Read_Data;
      if ((grant_mem & Mem_Read & Mem_Write) | drop_now | stray_rdy)
        Protocol_Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small wait-state RAM model.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        IF_Req;
  logic [31:0] IF_Address;
  logic        IF_Ack;
  logic [31:0] IF_Read_Data;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic        Mem_Ack;
  logic [31:0] Mem_Read_Data;
  logic        Stall_IF;
  logic        Stall_MEM;
  logic        Ram_Req;
  logic        Ram_We;
  logic [31:0] Ram_Address;
  logic [31:0] Ram_Write_Data;
  logic        Ram_Ready;
  logic [31:0] Ram_Read_Data;
  logic        Protocol_Error;

  int          checks;
  int          failures;
  int          wcnt;
  int          ram_wait;
  logic        ram_force;
  int          wr_count;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_Req         (IF_Req),
    .IF_Address     (IF_Address),
    .IF_Ack         (IF_Ack),
    .IF_Read_Data   (IF_Read_Data),
    .Mem_Read       (Mem_Read),
    .Mem_Write      (Mem_Write),
    .Mem_Address    (Mem_Address),
    .Mem_Write_Data (Mem_Write_Data),
    .Mem_Ack        (Mem_Ack),
    .Mem_Read_Data  (Mem_Read_Data),
    .Stall_IF       (Stall_IF),
    .Stall_MEM      (Stall_MEM),
    .Ram_Req        (Ram_Req),
    .Ram_We         (Ram_We),
    .Ram_Address    (Ram_Address),
    .Ram_Write_Data (Ram_Write_Data),
    .Ram_Ready      (Ram_Ready),
    .Ram_Read_Data  (Ram_Read_Data),
    .Protocol_Error (Protocol_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Ram_Ready = ram_force | (Ram_Req & (wcnt == ram_wait));

  always @(posedge clk) begin
    if (!Ram_Req || Ram_Ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (Ram_Req && Ram_Ready && Ram_We) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= Ram_Address;
      last_wr_data <= Ram_Write_Data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    wcnt = 0; ram_wait = 0; ram_force = 1'b0;
    wr_count = 0; last_wr_addr = '0; last_wr_data = '0;
    rst_n = 1'b0;
    IF_Req = 1'b0; IF_Address = '0;
    Mem_Read = 1'b0; Mem_Write = 1'b0;
    Mem_Address = '0; Mem_Write_Data = '0;
    Ram_Read_Data = '0;

    // reset state
    step(); step();
    chk("rst_ram_req", Ram_Req, 0);
    chk("rst_ram_we", Ram_We, 0);
    chk("rst_ram_addr", Ram_Address, 0);
    chk("rst_ram_wdata", Ram_Write_Data, 0);
    chk("rst_if_ack", IF_Ack, 0);
    chk("rst_mem_ack", Mem_Ack, 0);
    chk("rst_if_rdata", IF_Read_Data, 0);
    chk("rst_mem_rdata", Mem_Read_Data, 0);
    chk("rst_perr", Protocol_Error, 0);
    rst_n = 1'b1;
    step();

    // fetch only, zero-wait RAM
    IF_Req = 1'b1; IF_Address = 32'h40;
    Ram_Read_Data = 32'h8C01_0004; ram_wait = 0;
    #1;
    chk("t1_stall_c0", Stall_IF, 1);
    chk("t1_req_c0", Ram_Req, 0);
    step();
    chk("t1_req_c1", Ram_Req, 1);
    chk("t1_addr_c1", Ram_Address, 32'h40);
    chk("t1_we_c1", Ram_We, 0);
    chk("t1_stall_c1", Stall_IF, 1);
    chk("t1_ack_c1", IF_Ack, 0);
    step();
    chk("t1_ack_c2", IF_Ack, 1);
    chk("t1_req_c2", Ram_Req, 0);
    chk("t1_rdata", IF_Read_Data, 32'h8C01_0004);
    chk("t1_stall_c2", Stall_IF, 0);
    step();
    chk("t1_ack_c3", IF_Ack, 0);
    chk("t1_req_c3", Ram_Req, 0);
    chk("t1_perr", Protocol_Error, 0);
    IF_Req = 1'b0;
    step();

    // both ports continuously requesting
    IF_Req = 1'b1; IF_Address = 32'h80;
    Mem_Read = 1'b1; Mem_Address = 32'h200;
    Ram_Read_Data = 32'h1111_2222;
    for (int g = 0; g < 10; g++) begin
      logic is_if;
      is_if = ((g % 5) == 4);
      step();
      chk("t2_req", Ram_Req, 1);
      chk("t2_grant_addr", Ram_Address, is_if ? 32'h80 : 32'h200);
      chk("t2_streak", 32'(dut.u_streak.streak),
          is_if ? 32'd0 : 32'((g % 5) + 1));
      step();
      chk("t2_ack", is_if ? IF_Ack : Mem_Ack, 1);
      chk("t2_other_ack", is_if ? Mem_Ack : IF_Ack, 0);
      step();
      chk("t2_gap", Ram_Req, 0);
    end
    IF_Req = 1'b0; Mem_Read = 1'b0;
    step();
    chk("t2_mem_rdata", Mem_Read_Data, 32'h1111_2222);

    // store with three RAM wait cycles
    Mem_Write = 1'b1; Mem_Address = 32'h100;
    Mem_Write_Data = 32'hDEAD_BEEF; ram_wait = 3;
    Ram_Read_Data = 32'h5555_AAAA;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", Ram_Req, 1);
      chk("t3_we", Ram_We, 1);
      chk("t3_addr", Ram_Address, 32'h100);
      chk("t3_wdata", Ram_Write_Data, 32'hDEAD_BEEF);
      chk("t3_noack", Mem_Ack, 0);
      chk("t3_stall", Stall_MEM, 1);
      step();
    end
    chk("t3_ack", Mem_Ack, 1);
    chk("t3_req_done", Ram_Req, 0);
    chk("t3_rdata_kept", Mem_Read_Data, 32'h1111_2222);
    chk("t3_wr_count", wr_count, 1);
    chk("t3_wr_data", last_wr_data, 32'hDEAD_BEEF);
    step();
    chk("t3_ack_once", Mem_Ack, 0);
    Mem_Write = 1'b0;
    step();

    // reset in the middle of a data access
    Mem_Read = 1'b1; Mem_Address = 32'h300;
    IF_Req = 1'b1; IF_Address = 32'h44;
    ram_wait = 5;
    step();
    step();
    chk("t4_req_busy", Ram_Req, 1);
    chk("t4_addr_busy", Ram_Address, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("t4_req_rst", Ram_Req, 0);
    chk("t4_addr_rst", Ram_Address, 0);
    chk("t4_ifr_rst", IF_Read_Data, 0);
    chk("t4_memr_rst", Mem_Read_Data, 0);
    Mem_Read = 1'b0;
    ram_wait = 0; Ram_Read_Data = 32'h1234_5678;
    step();
    chk("t4_req_held", Ram_Req, 0);
    rst_n = 1'b1;
    step();
    chk("t4_if_req", Ram_Req, 1);
    chk("t4_if_addr", Ram_Address, 32'h44);
    step();
    chk("t4_if_ack", IF_Ack, 1);
    chk("t4_if_rdata", IF_Read_Data, 32'h1234_5678);
    chk("t4_perr", Protocol_Error, 0);
    step();
    IF_Req = 1'b0;
    step();

    // simultaneous read and write
    Mem_Read = 1'b1; Mem_Write = 1'b1;
    Mem_Address = 32'h180; Mem_Write_Data = 32'hCAFE_F00D;
    step();
    chk("t5_we", Ram_We, 1);
    chk("t5_perr", Protocol_Error, 1);
    step();
    chk("t5_ack", Mem_Ack, 1);
    chk("t5_wr_addr", last_wr_addr, 32'h180);
    chk("t5_wr_count", wr_count, 2);
    step();
    Mem_Read = 1'b0; Mem_Write = 1'b0;
    IF_Req = 1'b1; IF_Address = 32'h48; Ram_Read_Data = 32'h0BAD_C0DE;
    step();
    step();
    chk("t5_clean_ack", IF_Ack, 1);
    chk("t5_perr_sticky", Protocol_Error, 1);
    step();
    IF_Req = 1'b0;
    step();
    chk("t5_perr_sticky2", Protocol_Error, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_perr_rst", Protocol_Error, 0);
    step();
    rst_n = 1'b1;
    step();

    // fetch dropped before its ack
    IF_Req = 1'b1; IF_Address = 32'h4C; ram_wait = 2;
    Ram_Read_Data = 32'h7777_0000;
    step();
    step();
    IF_Req = 1'b0;
    step();
    chk("t6_perr", Protocol_Error, 1);
    chk("t6_in_flight", Ram_Req, 1);
    step();
    chk("t6_no_ack", IF_Ack, 0);
    chk("t6_req_done", Ram_Req, 0);
    chk("t6_idle", 32'(dut.state), 0);
    step();
    chk("t6_no_ack2", IF_Ack, 0);
    chk("t6_no_restart", Ram_Req, 0);

    // RAM ready while idle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t7_perr_clear", Protocol_Error, 0);
    ram_force = 1'b1;
    step();
    ram_force = 1'b0;
    chk("t7_perr_stray", Protocol_Error, 1);
    chk("t7_no_req", Ram_Req, 0);
    chk("t7_no_ack", IF_Ack | Mem_Ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
